// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end: fetch FSM states and
// instruction field positions.
package mips_pkg;

    localparam int INST_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    localparam logic [INST_W-1:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetchState_e;

endpackage

// File: rtl/instr_fetch_buffer.sv
// instr_buffer: DEPTH-entry FIFO of {instruction, pc} pairs sitting between
// instruction memory and decode. Head entry is presented combinationally.
module instr_buffer
    import mips_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              push,
    input  logic [INST_W-1:0] pushInst,
    input  logic [31:0]       pushPc,
    input  logic              pop,
    output logic              headValid,
    output logic [INST_W-1:0] headInst,
    output logic [31:0]       headPc,
    output logic [CNT_W-1:0]  count
);

    logic [INST_W-1:0] instMem [DEPTH];
    logic [31:0]       pcMem   [DEPTH];
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W-1:0]  rdPtr;

    // Entry storage; contents are only meaningful while counted as occupied
    always_ff @(posedge clk) begin
        if (push) begin
            instMem[wrPtr] <= pushInst;
            pcMem[wrPtr]   <= pushPc;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign headValid = (count != '0);
    assign headInst  = instMem[rdPtr];
    assign headPc    = pcMem[rdPtr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues one-at-a-time word reads to instruction
// memory and feeds returned words through instr_buffer to decode.
// Redirects from execute flush the buffer and retarget the PC; a request
// already in flight is drained (DRAIN) and its data discarded.
module instr_fetch
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [31:0]       imem_addr,
    input  logic              imem_rvalid,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_inst,
    output logic [5:0]        if_opcode,
    output logic [31:0]       if_pc,
    output logic [31:0]       if_pc_plus4
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetchState_e       state;
    fetchState_e       stateNext;
    logic [31:0]       pc;
    logic [31:0]       reqAddr;
    logic [31:0]       redirectTarget;
    logic [CNT_W-1:0]  count;
    logic              outstanding;
    logic              room;
    logic              roomAfterPush;
    logic              issue;
    logic              push;
    logic              pop;
    logic              headValid;
    logic [INST_W-1:0] headInst;
    logic [31:0]       headPc;

    // Every non-FETCH state has exactly one request in flight
    assign outstanding    = (state != FETCH);
    assign pop            = headValid & if_ready;
    assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
    assign room           = (int'(count) + int'(outstanding)) < DEPTH;
    assign roomAfterPush  = (int'(count) + 1 - int'(pop)) < DEPTH;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= FETCH;
        else        state <= stateNext;
    end

    // Next-state logic; redirect overrides everything except draining a stale request
    always_comb begin
        stateNext = state;
        case (state)
            FETCH: if (issue) stateNext = WAIT;
            WAIT: begin
                if (redirect_valid)              stateNext = imem_rvalid ? FETCH : DRAIN;
                else if (imem_rvalid && !issue)  stateNext = FETCH;
            end
            DRAIN: if (imem_rvalid) stateNext = FETCH;
            default: stateNext = FETCH;
        endcase
    end

    // Output logic: request issue and buffer push
    always_comb begin
        issue = 1'b0;
        push  = 1'b0;
        if (rst_n && !redirect_valid) begin
            case (state)
                FETCH: issue = room;
                WAIT: begin
                    if (imem_rvalid) begin
                        push  = 1'b1;
                        issue = roomAfterPush;
                    end
                end
                default: ;
            endcase
        end
    end

    // PC and address of the request in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= {RESET_PC[31:2], 2'b00};
            reqAddr <= '0;
        end else if (redirect_valid) begin
            pc <= redirectTarget;
        end else if (issue) begin
            pc      <= pc + 32'd4;
            reqAddr <= pc;
        end
    end

    instr_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .push      (push),
        .pushInst  (imem_rdata),
        .pushPc    (reqAddr),
        .pop       (pop),
        .headValid (headValid),
        .headInst  (headInst),
        .headPc    (headPc),
        .count     (count)
    );

    assign imem_req    = issue;
    assign imem_addr   = pc;
    assign if_valid    = headValid;
    assign if_inst     = headValid ? headInst : NOP;
    assign if_pc       = headValid ? headPc : 32'h0000_0000;
    assign if_opcode   = if_inst[OPCODE_MSB:OPCODE_LSB];
    assign if_pc_plus4 = if_pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_inst;
    logic [5:0]  if_opcode;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    instr_fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_inst        (if_inst),
        .if_opcode      (if_opcode),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // memory / stimulus state
    int          now = 0;
    int          memLat = 1;
    bit          randLat = 0;
    bit          injectStray = 0;
    bit          pendValid = 0;
    bit          pendStale = 0;
    logic [31:0] pendAddr = 32'h0;
    int          pendDue = 0;
    logic        drvReady = 1'b0;
    logic        drvRedirect = 1'b0;
    logic [31:0] drvTarget = 32'h0;

    // reference model: expected instruction stream and buffer occupancy
    logic [31:0] expPc = RESET_PC;
    logic [31:0] expReqAddr = RESET_PC;
    int          modelCount = 0;

    // samples taken each cycle
    logic [31:0] sReq, sValid, sAddr, sInst, sPc, sPc4, sOp;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[7:2] ^ 6'h15, a[27:2]};
    endfunction

    function automatic logic [31:0] align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        modelCount = 0;
        pendValid  = 0;
        pendStale  = 0;
        expPc      = RESET_PC;
        expReqAddr = RESET_PC;
        now        = 0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        imem_rvalid = 1'b0;
        redirect_valid = 1'b0;
        if_ready = 1'b0;
        #1;
        chk("rst_req",    32'(imem_req), 32'd0);
        chk("rst_valid",  32'(if_valid), 32'd0);
        chk("rst_inst",   if_inst, 32'd0);
        chk("rst_pc",     if_pc, 32'd0);
        chk("rst_pc4",    if_pc_plus4, 32'd4);
        chk("rst_opcode", 32'(if_opcode), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
        drvRedirect = 1'b0;
        drvReady = 1'b0;
    endtask

    // One clock cycle: drive memory/decode/redirect, sample, check, update model
    task automatic cycle();
        bit          respond, hs, pushAcc, legal;
        int          newCount;
        logic [31:0] w;
        respond = 0;
        imem_rvalid = 1'b0;
        imem_rdata = $urandom;
        if (pendValid && now >= pendDue) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(pendAddr);
            respond     = 1;
        end else if (injectStray && !pendValid) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hDEAD_BEEF;
        end
        injectStray = 0;
        if_ready = drvReady;
        redirect_valid = drvRedirect;
        redirect_pc = drvTarget;
        #1;
        sReq   = 32'(imem_req);
        sAddr  = imem_addr;
        sValid = 32'(if_valid);
        sInst  = if_inst;
        sPc    = if_pc;
        sPc4   = if_pc_plus4;
        sOp    = 32'(if_opcode);

        chk("if_valid", sValid, 32'(modelCount > 0));
        if (sValid != 0) begin
            w = memWord(expPc);
            chk("if_pc", sPc, expPc);
            chk("if_inst", sInst, w);
            chk("if_opcode", sOp, 32'(w[31:26]));
            chk("if_pc_plus4", sPc4, expPc + 32'd4);
        end

        hs       = (sValid != 0) && drvReady && (modelCount > 0);
        pushAcc  = respond && !pendStale && !drvRedirect;
        newCount = drvRedirect ? 0 : modelCount + int'(pushAcc) - int'(hs);
        legal    = !drvRedirect && !(pendValid && !respond) && (newCount < DEPTH);
        if (!legal) chk("req_blocked", sReq, 32'd0);
        if (sReq != 0) chk("req_addr", sAddr, expReqAddr);

        if (hs) expPc = expPc + 32'd4;
        modelCount = newCount;
        if (respond) pendValid = 0;
        if (drvRedirect) begin
            expPc      = align(drvTarget);
            expReqAddr = align(drvTarget);
            if (pendValid) pendStale = 1;
        end
        if (sReq != 0) begin
            pendValid  = 1;
            pendStale  = 0;
            pendAddr   = expReqAddr;
            pendDue    = now + (randLat ? int'($urandom_range(1, 4)) : memLat);
            expReqAddr = expReqAddr + 32'd4;
        end
        @(posedge clk);
        now++;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] w;
        bit          seen;
        int          n;
        @(negedge clk);

        // back-to-back fetch with 1-cycle memory
        applyReset();
        memLat = 1; randLat = 0; drvReady = 1'b1;
        cycle();
        chk("t1_req0", sReq, 32'd1);
        chk("t1_addr0", sAddr, 32'h0);
        chk("t1_valid0", sValid, 32'd0);
        cycle();
        chk("t1_req1", sReq, 32'd1);
        chk("t1_addr1", sAddr, 32'h4);
        cycle();
        chk("t1_addr2", sAddr, 32'h8);
        chk("t1_valid2", sValid, 32'd1);
        chk("t1_pc2", sPc, 32'h0);
        w = memWord(32'h0);
        chk("t1_opcode2", sOp, 32'(w[31:26]));
        cycle();
        chk("t1_addr3", sAddr, 32'hC);
        chk("t1_pc3", sPc, 32'h4);
        repeat (12) begin
            cycle();
            chk("t1_stream_req", sReq, 32'd1);
            chk("t1_stream_valid", sValid, 32'd1);
        end

        // decode stalled: buffer fills, then drains in order
        applyReset();
        memLat = 1; drvReady = 1'b0;
        cycle();
        cycle();
        chk("t2_req1", sAddr, 32'h4);
        cycle();
        chk("t2_full_noreq", sReq, 32'd0);
        repeat (4) begin
            cycle();
            chk("t2_hold_req", sReq, 32'd0);
            chk("t2_hold_pc", sPc, 32'h0);
        end
        drvReady = 1'b1;
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            cycle();
            if (sReq != 0) begin
                seen = 1;
                chk("t2_resume_addr", sAddr, 32'h8);
            end
        end
        chk("t2_resume_seen", 32'(seen), 32'd1);
        repeat (6) cycle();

        // redirect while waiting on a slow memory
        applyReset();
        memLat = 3; drvReady = 1'b1;
        cycle();
        drvRedirect = 1'b1; drvTarget = 32'h0000_0103;
        cycle();
        chk("t3_redirect_noreq", sReq, 32'd0);
        drvRedirect = 1'b0;
        seen = 0; n = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            n++;
            chk("t3_valid_low", sValid, 32'd0);
            if (sReq != 0) begin
                seen = 1;
                chk("t3_target_addr", sAddr, 32'h0000_0100);
            end
        end
        chk("t3_req_seen", 32'(seen), 32'd1);
        chk("t3_drain_cycles", 32'(n), 32'd3);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            cycle();
            if (sValid != 0) begin
                seen = 1;
                chk("t3_first_pc", sPc, 32'h0000_0100);
            end
        end
        chk("t3_valid_seen", 32'(seen), 32'd1);

        // redirect coincident with response
        applyReset();
        memLat = 1; drvReady = 1'b1;
        cycle();
        drvRedirect = 1'b1; drvTarget = 32'h0000_0040;
        cycle();
        chk("t4_redirect_noreq", sReq, 32'd0);
        drvRedirect = 1'b0;
        cycle();
        chk("t4_empty", sValid, 32'd0);
        chk("t4_req", sReq, 32'd1);
        chk("t4_addr", sAddr, 32'h0000_0040);
        repeat (4) cycle();

        // reset with a buffered word and a request outstanding
        applyReset();
        memLat = 3; drvReady = 1'b0;
        repeat (5) cycle();
        chk("t5_buffered", sValid, 32'd1);
        applyReset();
        memLat = 1; drvReady = 1'b1; injectStray = 1;
        cycle();
        chk("t5_req", sReq, 32'd1);
        chk("t5_addr", sAddr, RESET_PC);
        chk("t5_valid", sValid, 32'd0);
        cycle();
        cycle();
        chk("t5_first_pc", sPc, RESET_PC);
        chk("t5_first_inst", sInst, memWord(RESET_PC));

        // PC wrap at the top of the address space
        applyReset();
        memLat = 1; drvReady = 1'b1;
        drvRedirect = 1'b1; drvTarget = 32'hFFFF_FFF8;
        cycle();
        chk("t6_redirect_noreq", sReq, 32'd0);
        drvRedirect = 1'b0;
        cycle();
        chk("t6_addr0", sAddr, 32'hFFFF_FFF8);
        cycle();
        chk("t6_addr1", sAddr, 32'hFFFF_FFFC);
        cycle();
        chk("t6_addr2", sAddr, 32'h0000_0000);
        chk("t6_pc0", sPc, 32'hFFFF_FFF8);
        cycle();
        chk("t6_pc1", sPc, 32'hFFFF_FFFC);
        chk("t6_pc4_wrap", sPc4, 32'h0000_0000);

        // random traffic against the reference model
        applyReset();
        randLat = 1;
        for (int i = 0; i < 800; i++) begin
            drvReady    = ($urandom_range(0, 3) != 0);
            drvRedirect = ($urandom_range(0, 15) == 0);
            drvTarget   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            injectStray = ($urandom_range(0, 7) == 0);
            cycle();
        end
        drvRedirect = 1'b0;
        drvReady = 1'b1;
        repeat (10) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
